// File: rtl/mem_arbiter_v1_if.sv
// Bundle of the two requester ports and the memory-unit pins around mem_arbiter_v1.
// master is the arbiter side; slave is the requesters plus memory unit.
interface mem_arbiter_v1_if #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned data_width = 32
);
    logic                  if_req;
    logic [addr_width-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [data_width-1:0] if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [addr_width-1:0] dm_addr;
    logic [data_width-1:0] dm_wdata;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [data_width-1:0] dm_rdata;

    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_data_in;
    logic                  mem_write_enable;
    logic                  mem_read_enable;
    logic [data_width-1:0] mem_data_out;

    logic                  busy;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_addr, mem_data_in, mem_write_enable, mem_read_enable, busy
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_addr, mem_data_in, mem_write_enable, mem_read_enable, busy
    );
endinterface

// File: rtl/mem_arbiter_v1.sv
// Two-requester arbiter for a single-port memory with fixed read latency.
// DM has priority; IF is forced through after max_starve consecutive losses.
module mem_arbiter_v1 #(
    parameter int unsigned addr_width   = 10,
    parameter int unsigned data_width   = 32,
    parameter int unsigned read_latency = 1,
    parameter int unsigned max_starve   = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_v1_if.master bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic [1:0]            lat_q, lat_d;
    logic                  owner_dm_q, owner_dm_d;
    logic                  if_gnt_q, if_gnt_d;
    logic                  dm_gnt_q, dm_gnt_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  dm_rvalid_q, dm_rvalid_d;
    logic [data_width-1:0] if_rdata_q, if_rdata_d;
    logic [data_width-1:0] dm_rdata_q, dm_rdata_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [data_width-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  busy_q, busy_d;
    logic                  pick_if;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        lat_d       = lat_q;
        owner_dm_d  = owner_dm_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        pick_if     = bus.if_req && (!bus.dm_req || starve_q >= 4'(max_starve));

        unique case (state_q)
            StIdle: begin
                if (!bus.if_req) begin
                    starve_d = '0;
                end
                if (bus.if_req || bus.dm_req) begin
                    state_d = StAccess;
                    if (pick_if) begin
                        owner_dm_d = 1'b0;
                        if_gnt_d   = 1'b1;
                        mem_addr_d = bus.if_addr;
                        mem_re_d   = 1'b1;
                        starve_d   = '0;
                    end else begin
                        owner_dm_d  = 1'b1;
                        dm_gnt_d    = 1'b1;
                        mem_addr_d  = bus.dm_addr;
                        mem_we_d    = bus.dm_we;
                        mem_re_d    = !bus.dm_we;
                        mem_wdata_d = bus.dm_we ? bus.dm_wdata : '0;
                        // IF lost this round; saturate at the forcing threshold
                        if (bus.if_req && starve_q < 4'(max_starve)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            StAccess: begin
                if (mem_we_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                    lat_d   = 2'(read_latency - 1);
                end
            end
            StWait: begin
                if (lat_q == 2'd0) begin
                    state_d = StResp;
                    if (owner_dm_q) begin
                        dm_rdata_d  = bus.mem_data_out;
                        dm_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = bus.mem_data_out;
                        if_rvalid_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            lat_q       <= '0;
            owner_dm_q  <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            lat_q       <= lat_d;
            owner_dm_q  <= owner_dm_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_gnt           = if_gnt_q;
    assign bus.dm_gnt           = dm_gnt_q;
    assign bus.if_rvalid        = if_rvalid_q;
    assign bus.dm_rvalid        = dm_rvalid_q;
    assign bus.if_rdata         = if_rdata_q;
    assign bus.dm_rdata         = dm_rdata_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_data_in      = mem_wdata_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_read_enable  = mem_re_q;
    assign bus.busy             = busy_q;
endmodule
